// File: rtl/dsram_port_sched_if.sv
// dsram_port_sched_if: request, store-buffer, flush and data SRAM signals of the port scheduler.
interface dsram_port_sched_if;
    logic        ld_req_valid;
    logic [31:0] ld_req_addr;
    logic        ld_req_ready;
    logic        ld_rdata_valid;
    logic [31:0] ld_rdata;
    logic        sb_req_valid;
    logic [31:0] sb_req_addr;
    logic [3:0]  sb_req_wen;
    logic [31:0] sb_req_wdata;
    logic        sb_req_ready;
    logic [4:0]  sb_count;
    logic        sb_addr_hit;
    logic        flush_req;
    logic        flush_done;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output ld_req_valid, ld_req_addr, sb_req_valid, sb_req_addr, sb_req_wen, sb_req_wdata,
               sb_count, sb_addr_hit, flush_req, data_sram_rdata,
        input  ld_req_ready, ld_rdata_valid, ld_rdata, sb_req_ready, flush_done,
               data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
    );

    modport slave (
        input  ld_req_valid, ld_req_addr, sb_req_valid, sb_req_addr, sb_req_wen, sb_req_wdata,
               sb_count, sb_addr_hit, flush_req, data_sram_rdata,
        output ld_req_ready, ld_rdata_valid, ld_rdata, sb_req_ready, flush_done,
               data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
    );
endinterface

// File: rtl/dsram_port_sched.sv
// dsram_port_sched: arbitrates the single data SRAM port between MEM-stage loads and store-buffer drains.
module dsram_port_sched #(
    parameter int SB_DEPTH   = 16,
    parameter int HIGH_WM    = 12,
    parameter int LOW_WM     = 4,
    parameter int STARVE_MAX = 8
) (
    input logic clk,
    input logic resetn,
    dsram_port_sched_if.slave bus
);
    localparam int CW = $clog2(SB_DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] HWM  = CW'(HIGH_WM);
    localparam logic [CW-1:0] LWM  = CW'(LOW_WM);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    typedef enum logic [1:0] {NORMAL, DRAIN, FLUSH} state_t;

    state_t        state, state_nx;
    logic [SW-1:0] starve_cnt;
    logic          ld_gnt, sb_gnt, store_mode, flush_done_nx;
    logic          ld_rdata_valid, flush_done;

    // DRAIN releases loads in the very cycle occupancy falls to the low watermark
    always_comb begin
        store_mode = state == FLUSH || (state == DRAIN && bus.sb_count > LWM);
        sb_gnt     = bus.sb_req_valid && (store_mode || starve_cnt == SMAX || !bus.ld_req_valid || bus.sb_addr_hit);
        ld_gnt     = !store_mode && bus.ld_req_valid && !bus.sb_addr_hit && !sb_gnt;
    end

    always_comb begin
        state_nx      = state;
        flush_done_nx = 1'b0;
        if (state == FLUSH) begin
            state_nx      = bus.sb_count == '0 ? NORMAL : FLUSH;
            flush_done_nx = bus.sb_count == '0;
        end else if (bus.flush_req) begin
            state_nx      = bus.sb_count == '0 ? NORMAL : FLUSH;
            flush_done_nx = bus.sb_count == '0;
        end else if (state == NORMAL && bus.sb_count >= HWM) begin
            state_nx = DRAIN;
        end else if (state == DRAIN && bus.sb_count <= LWM) begin
            state_nx = NORMAL;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= NORMAL;
            starve_cnt     <= '0;
            ld_rdata_valid <= 1'b0;
            flush_done     <= 1'b0;
        end else begin
            state          <= state_nx;
            starve_cnt     <= (sb_gnt || !bus.sb_req_valid) ? '0 :
                              (ld_gnt && starve_cnt != SMAX) ? starve_cnt + 1'b1 : starve_cnt;
            ld_rdata_valid <= ld_gnt;
            flush_done     <= flush_done_nx;
        end
    end

    assign bus.ld_req_ready    = ld_gnt;
    assign bus.sb_req_ready    = sb_gnt;
    assign bus.data_sram_en    = ld_gnt || sb_gnt;
    assign bus.data_sram_wen   = sb_gnt ? bus.sb_req_wen : 4'h0;
    assign bus.data_sram_addr  = sb_gnt ? bus.sb_req_addr : ld_gnt ? bus.ld_req_addr : 32'h0;
    assign bus.data_sram_wdata = sb_gnt ? bus.sb_req_wdata : 32'h0;
    assign bus.ld_rdata_valid  = ld_rdata_valid;
    assign bus.ld_rdata        = ld_rdata_valid ? bus.data_sram_rdata : 32'h0;
    assign bus.flush_done      = flush_done;
endmodule
